// File: rtl/pe_mp_acc.sv
// Mixed-precision MAC processing element: sub-word signed multiply,
// saturating accumulate, activation and psum chain drain.
module pe_mp_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int CLIP_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic [1:0]            i_mode,
  input  logic [1:0]            i_act_mode,
  input  logic [CLIP_WIDTH-1:0] i_clip,
  input  logic [DATA_WIDTH-1:0] i_ifmap,
  input  logic [DATA_WIDTH-1:0] i_weight,
  input  logic                  i_valid,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_ifmap,
  output logic [DATA_WIDTH-1:0] o_weight,
  output logic                  o_fwd_valid,
  input  logic [ACC_WIDTH-1:0]  i_psum,
  input  logic                  i_psum_valid,
  output logic [ACC_WIDTH-1:0]  o_ofmap,
  output logic                  o_ofmap_valid,
  input  logic                  i_ofmap_ready,
  output logic                  o_sat
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam int QW = DATA_WIDTH / 4;
  localparam int AX = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_HOLD
  } state_t;

  state_t state, state_nx;

  logic                        accept;
  logic                        hs;
  logic                        p_vld;
  logic                        ovf;
  logic signed [PW-1:0]        prod_full;
  logic signed [PW-1:0]        prod_half;
  logic signed [PW-1:0]        prod_quad;
  logic signed [PW-1:0]        prod_sel;
  logic signed [ACC_WIDTH-1:0] p_next;
  logic signed [ACC_WIDTH-1:0] p_reg;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sat;
  logic signed [ACC_WIDTH-1:0] max_v;
  logic signed [ACC_WIDTH-1:0] min_v;
  logic signed [ACC_WIDTH-1:0] relu;
  logic signed [ACC_WIDTH-1:0] clip_v;
  logic signed [AX-1:0]        acc_sum;

  assign o_ready       = (state == S_IDLE) || (state == S_ACCUM);
  assign o_ofmap_valid = (state == S_HOLD);
  assign accept        = i_valid & o_ready;
  assign hs            = (state == S_HOLD) & i_ofmap_ready;

  always_comb begin
    prod_full = PW'($signed(i_ifmap)) * PW'($signed(i_weight));
    prod_half = '0;
    prod_quad = '0;
    for (int k = 0; k < 2; k++) begin
      prod_half = prod_half
        + PW'($signed(i_ifmap[k*HW +: HW]))
        * PW'($signed(i_weight[k*HW +: HW]));
    end
    for (int k = 0; k < 4; k++) begin
      prod_quad = prod_quad
        + PW'($signed(i_ifmap[k*QW +: QW]))
        * PW'($signed(i_weight[k*QW +: QW]));
    end
    case (i_mode)
      2'b01:   prod_sel = prod_half;
      2'b10:   prod_sel = prod_quad;
      default: prod_sel = prod_full;
    endcase
    p_next = ACC_WIDTH'(prod_sel);
  end

  // Wide add, then clamp on sign disagreement of the top two bits
  assign acc_sum = AX'(acc) + AX'(p_reg);
  assign ovf     = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
  assign max_v   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign min_v   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign acc_sat = !ovf ? acc_sum[ACC_WIDTH-1:0]
                 : (acc_sum[ACC_WIDTH] ? min_v : max_v);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_ACCUM: begin
        if (accept) state_nx = i_last ? S_FLUSH : S_ACCUM;
      end
      S_FLUSH: state_nx = S_HOLD;
      S_HOLD: begin
        if (hs && !i_psum_valid) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      acc   <= '0;
      p_reg <= '0;
      p_vld <= 1'b0;
      o_sat <= 1'b0;
    end else if (i_clear) begin
      state <= S_IDLE;
      acc   <= '0;
      p_vld <= 1'b0;
      o_sat <= 1'b0;
    end else begin
      state <= state_nx;
      p_vld <= accept;
      if (accept) p_reg <= p_next;
      if (hs) begin
        acc   <= i_psum_valid ? i_psum : '0;
        o_sat <= 1'b0;
      end else if (p_vld) begin
        acc <= acc_sat;
        if (ovf) o_sat <= 1'b1;
      end else if (accept && state == S_IDLE) begin
        o_sat <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ifmap     <= '0;
      o_weight    <= '0;
      o_fwd_valid <= 1'b0;
    end else begin
      o_fwd_valid <= accept;
      if (accept) begin
        o_ifmap  <= i_ifmap;
        o_weight <= i_weight;
      end
    end
  end

  assign relu   = acc[ACC_WIDTH-1] ? '0 : acc;
  assign clip_v = ACC_WIDTH'(i_clip);

  always_comb begin
    o_ofmap = acc;
    unique case (1'b1)
      i_act_mode == 2'b00: o_ofmap = acc;
      i_act_mode == 2'b01: o_ofmap = relu;
      i_act_mode[1]:       o_ofmap = (relu > clip_v) ? clip_v : relu;
    endcase
  end

endmodule

// File: tb/tb_pe_mp_acc.sv
// Bench for pe_mp_acc: window-level reference model plus directed
// vectors on a 24-bit and a 16-bit accumulator instance.
module tb_pe_mp_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, vld, lst, psv, ordy;
  logic [1:0]  mode, amode;
  logic [7:0]  clip, ifm, wgt;
  logic [23:0] psum;

  logic        w_ready, w_fv, w_ov, w_sat;
  logic [7:0]  w_ifm, w_wgt;
  logic [23:0] w_of;
  logic        n_ready, n_fv, n_ov, n_sat;
  logic [7:0]  n_ifm, n_wgt;
  logic [15:0] n_of;

  pe_mp_acc dut_w (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_mode(mode), .i_act_mode(amode), .i_clip(clip),
    .i_ifmap(ifm), .i_weight(wgt), .i_valid(vld), .i_last(lst),
    .o_ready(w_ready), .o_ifmap(w_ifm), .o_weight(w_wgt),
    .o_fwd_valid(w_fv), .i_psum(psum), .i_psum_valid(psv),
    .o_ofmap(w_of), .o_ofmap_valid(w_ov),
    .i_ofmap_ready(ordy), .o_sat(w_sat)
  );

  pe_mp_acc #(.ACC_WIDTH(16)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_mode(mode), .i_act_mode(amode), .i_clip(clip),
    .i_ifmap(ifm), .i_weight(wgt), .i_valid(vld), .i_last(lst),
    .o_ready(n_ready), .o_ifmap(n_ifm), .o_weight(n_wgt),
    .o_fwd_valid(n_fv), .i_psum(psum[15:0]), .i_psum_valid(psv),
    .o_ofmap(n_of), .o_ofmap_valid(n_ov),
    .i_ofmap_ready(ordy), .o_sat(n_sat)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint lane_sum(input logic [1:0] md,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    int n, l;
    longint s, x, y, span;
    n = (md == 2'd1) ? 2 : (md == 2'd2) ? 4 : 1;
    l = 8 / n;
    span = longint'(1) << l;
    s = 0;
    for (int k = 0; k < n; k++) begin
      x = (longint'(a) >> (k * l)) % span;
      y = (longint'(b) >> (k * l)) % span;
      if (x >= span / 2) x -= span;
      if (y >= span / 2) y -= span;
      s += x * y;
    end
    return s;
  endfunction

  function automatic longint clamp24(input longint v);
    longint lim;
    lim = longint'(1) << 23;
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic longint act(input longint v, input logic [1:0] am,
                                 input logic [7:0] c);
    longint r;
    if (am == 2'd0) return v;
    r = (v < 0) ? 0 : v;
    if (am == 2'd1) return r;
    return (r > longint'(c)) ? longint'(c) : r;
  endfunction

  // Reference model: window phase 0=open, 1=flush, 2=hold
  int         ph;
  bit         inwin, pv, msat, mfv, started = 0;
  longint     macc, pprod;
  logic [7:0] mfi, mfw;

  always @(posedge clk) begin
    int p0;
    longint s;
    if (rst) begin
      ph = 0; inwin = 0; pv = 0; macc = 0; msat = 0;
      mfi = 0; mfw = 0; mfv = 0; started = 1;
    end else begin
      p0 = ph;
      mfv = vld && (p0 == 0);
      if (mfv) begin
        mfi = ifm;
        mfw = wgt;
      end
      if (clr) begin
        ph = 0; inwin = 0; pv = 0; macc = 0; msat = 0;
      end else begin
        if (p0 == 2 && ordy) begin
          macc = psv ? longint'($signed(psum)) : 0;
          msat = 0;
          if (!psv) begin
            ph = 0;
            inwin = 0;
          end
        end else if (pv) begin
          s = macc + pprod;
          if (clamp24(s) != s) msat = 1;
          macc = clamp24(s);
        end
        pv = 0;
        if (p0 == 0 && vld) begin
          if (!inwin) msat = 0;
          inwin = 1;
          pprod = lane_sum(mode, ifm, wgt);
          pv = 1;
          if (lst) ph = 1;
        end else if (p0 == 1) begin
          ph = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_ready", w_ready, ph == 0);
      chk("m_ofv", w_ov, ph == 2);
      chk("m_sat", w_sat, msat);
      chk("m_fwdv", w_fv, mfv);
      chk("m_fwd_if", w_ifm, mfi);
      chk("m_fwd_w", w_wgt, mfw);
      if (ph == 2)
        chk("m_ofmap", longint'($signed(w_of)), act(macc, amode, clip));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic l);
    vld = 1'b1; ifm = a; wgt = b; lst = l;
    tick();
    vld = 1'b0; lst = 1'b0;
  endtask

  task automatic expect_result(input string nm, input longint exp);
    @(negedge clk);
    chk({nm, "_flush_v"}, w_ov, 0);
    tick();
    @(negedge clk);
    chk({nm, "_lat_v"}, w_ov, 1);
    chk(nm, longint'($signed(w_of)), exp);
  endtask

  task automatic drain(input logic p, input logic [23:0] v);
    ordy = 1'b1; psv = p; psum = v;
    tick();
    ordy = 1'b0; psv = 1'b0;
  endtask

  initial begin
    rst = 1; clr = 0; vld = 0; lst = 0; psv = 0; ordy = 0;
    mode = 0; amode = 0; clip = 0; ifm = 0; wgt = 0; psum = 0;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_ofv", w_ov, 0);
    chk("rst_fwdv", w_fv, 0);
    chk("rst_ifm", w_ifm, 0);
    chk("rst_sat", w_sat, 0);
    chk("rst_ofmap", w_of, 0);
    chk("rst_ready", w_ready, 1);
    tick();

    send(8'd3, 8'd4, 0);
    send(8'hFE, 8'd5, 0);
    send(8'd7, 8'hFF, 1);
    expect_result("m00_none", -5);
    chk("n_m00_none", longint'($signed(n_of)), -5);
    drain(0, 0);

    amode = 2'd1;
    send(8'd3, 8'd4, 0);
    send(8'hFE, 8'd5, 0);
    send(8'd7, 8'hFF, 1);
    expect_result("m00_relu", 0);
    drain(0, 0);

    amode = 2'd0;
    mode = 2'd1;
    send(8'h3F, 8'h2E, 1);
    expect_result("m01", 8);
    drain(0, 0);

    mode = 2'd2;
    send(8'h79, 8'h55, 1);
    expect_result("m10", -1);
    drain(0, 0);

    mode = 2'd3;
    send(8'd5, 8'd6, 1);
    expect_result("m11", 30);
    drain(0, 0);

    mode = 2'd0;
    send(8'd127, 8'd127, 0);
    send(8'd127, 8'd127, 0);
    send(8'd127, 8'd127, 1);
    expect_result("sat_wide", 48387);
    chk("n_sat_val", longint'($signed(n_of)), 32767);
    chk("n_sat_flag", n_sat, 1);
    chk("w_sat_flag", w_sat, 0);
    drain(0, 0);
    send(8'd1, 8'd1, 1);
    expect_result("after_sat", 1);
    chk("n_after_val", longint'($signed(n_of)), 1);
    chk("n_after_sat", n_sat, 0);
    drain(0, 0);

    amode = 2'd2;
    clip = 8'd6;
    send(8'd10, 8'd10, 1);
    expect_result("clip6", 6);
    tick();
    clip = 8'd255;
    @(negedge clk);
    chk("clip255", longint'($signed(w_of)), 100);
    drain(0, 0);

    amode = 2'd0;
    send(8'd2, 8'd3, 1);
    expect_result("bp", 6);
    vld = 1; ifm = 8'd9; wgt = 8'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_val", longint'($signed(w_of)), 6);
      chk("bp_hold_rdy", w_ready, 0);
      chk("bp_hold_ov", w_ov, 1);
    end
    tick();
    vld = 0;
    drain(1, 24'd42);
    @(negedge clk);
    chk("chain_val", longint'($signed(w_of)), 42);
    chk("chain_ov", w_ov, 1);
    chk("n_chain_val", longint'($signed(n_of)), 42);
    drain(0, 0);
    @(negedge clk);
    chk("idle_rdy", w_ready, 1);
    chk("idle_ov", w_ov, 0);
    chk("idle_acc", w_of, 0);
    tick();

    send(8'd4, 8'd4, 0);
    send(8'd5, 8'd5, 0);
    clr = 1;
    tick();
    clr = 0;
    @(negedge clk);
    chk("clr_rdy", w_ready, 1);
    chk("clr_acc", w_of, 0);
    tick();
    @(negedge clk);
    chk("clr_acc2", w_of, 0);
    tick();

    send(8'd1, 8'd2, 1);
    expect_result("pre_rst", 2);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("hrst_ov", w_ov, 0);
    chk("hrst_of", w_of, 0);
    chk("hrst_ifm", w_ifm, 0);
    chk("hrst_wgt", w_wgt, 0);
    chk("hrst_fv", w_fv, 0);
    chk("hrst_sat", w_sat, 0);
    chk("hrst_n_ov", n_ov, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
